// File: rtl/shift_reg_universal.sv
// Universal shift register with per-cycle mode select and a serial frame counter
// that captures each completed word. Optional: SHIFT_REG_ARITH_SHIFT_EN (MODE 111 = arithmetic shift right).
module shift_reg_universal #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         EN,
  input  logic [2:0]                   MODE,
  input  logic                         SIN_L,
  input  logic                         SIN_R,
  input  logic [WIDTH-1:0]             PIN,
  output logic [WIDTH-1:0]             POUT,
  output logic                         SOUT_L,
  output logic                         SOUT_R,
  output logic [$clog2(FRAME_LEN)-1:0] BITCNT,
  output logic [WIDTH-1:0]             WORD_OUT,
  output logic                         WORD_VLD
);

  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_AUX   = 3'b111
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] pout_q, pout_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [WIDTH-1:0] word_q, word_nxt;
  logic             vld_q, vld_nxt;
  logic             counting;

  assign mode = mode_e'(MODE);

  always_comb begin
    pout_nxt = pout_q;
    cnt_nxt  = cnt_q;
    word_nxt = word_q;
    vld_nxt  = 1'b0;
    counting = 1'b0;
    if (EN) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHL: begin
          pout_nxt = {pout_q[WIDTH-2:0], SIN_L};
          counting = 1'b1;
        end
        MODE_SHR: begin
          pout_nxt = {SIN_R, pout_q[WIDTH-1:1]};
          counting = 1'b1;
        end
        MODE_ROL:  pout_nxt = {pout_q[WIDTH-2:0], pout_q[WIDTH-1]};
        MODE_ROR:  pout_nxt = {pout_q[0], pout_q[WIDTH-1:1]};
        MODE_LOAD: begin
          pout_nxt = PIN;
          cnt_nxt  = '0;
        end
        MODE_CLEAR: begin
          pout_nxt = '0;
          cnt_nxt  = '0;
        end
        MODE_AUX: begin
`ifdef SHIFT_REG_ARITH_SHIFT_EN
          pout_nxt = {pout_q[WIDTH-1], pout_q[WIDTH-1:1]};
`endif
        end
        default: ;
      endcase
      // The captured word is the post-shift value, so it is taken from pout_nxt.
      if (counting) begin
        if (cnt_q == CW'(FRAME_LEN - 1)) begin
          cnt_nxt  = '0;
          word_nxt = pout_nxt;
          vld_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pout_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      pout_q <= pout_nxt;
      cnt_q  <= cnt_nxt;
      word_q <= word_nxt;
      vld_q  <= vld_nxt;
    end
  end

  assign POUT     = pout_q;
  assign SOUT_L   = pout_q[WIDTH-1];
  assign SOUT_R   = pout_q[0];
  assign BITCNT   = cnt_q;
  assign WORD_OUT = word_q;
  assign WORD_VLD = vld_q;

endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal (WIDTH=8, FRAME_LEN=8): directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_shift_reg_universal;

  localparam int W  = 8;
  localparam int FL = 8;
  localparam int CW = $clog2(FL);

  logic          CLK = 1'b0;
  logic          RST_N, EN, SIN_L, SIN_R;
  logic [2:0]    MODE;
  logic [W-1:0]  PIN, POUT, WORD_OUT;
  logic          SOUT_L, SOUT_R, WORD_VLD;
  logic [CW-1:0] BITCNT;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int unsigned m_reg, m_cnt, m_word, m_vld;

  shift_reg_universal #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE), .SIN_L(SIN_L), .SIN_R(SIN_R),
    .PIN(PIN), .POUT(POUT), .SOUT_L(SOUT_L), .SOUT_R(SOUT_R), .BITCNT(BITCNT),
    .WORD_OUT(WORD_OUT), .WORD_VLD(WORD_VLD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int unsigned mask;
    bit          cnt_shift;
    mask      = (1 << W) - 1;
    cnt_shift = 0;
    m_vld     = 0;
    if (!RST_N) begin
      m_reg = 0; m_cnt = 0; m_word = 0;
    end else if (EN) begin
      case (MODE)
        3'd1: begin m_reg = ((m_reg * 2) + SIN_L) & mask; cnt_shift = 1; end
        3'd2: begin m_reg = (m_reg / 2) + (SIN_R ? (1 << (W-1)) : 0); cnt_shift = 1; end
        3'd3: m_reg = ((m_reg * 2) & mask) + (m_reg >> (W-1));
        3'd4: m_reg = (m_reg / 2) + ((m_reg % 2) << (W-1));
        3'd5: begin m_reg = PIN; m_cnt = 0; end
        3'd6: begin m_reg = 0; m_cnt = 0; end
        3'd7: begin
`ifdef SHIFT_REG_ARITH_SHIFT_EN
          m_reg = (m_reg / 2) + (m_reg & (1 << (W-1)));
`endif
        end
        default: ;
      endcase
      if (cnt_shift) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == FL) begin
          m_cnt  = 0;
          m_word = m_reg;
          m_vld  = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("POUT",     POUT,     m_reg);
    check("SOUT_L",   SOUT_L,   (m_reg >> (W-1)) & 1);
    check("SOUT_R",   SOUT_R,   m_reg & 1);
    check("BITCNT",   BITCNT,   m_cnt);
    check("WORD_OUT", WORD_OUT, m_word);
    check("WORD_VLD", WORD_VLD, m_vld);
  endtask

  task automatic step(input logic rst_n, input logic en, input logic [2:0] mode,
                      input logic sl, input logic sr, input logic [W-1:0] pin);
    RST_N = rst_n; EN = en; MODE = mode; SIN_L = sl; SIN_R = sr; PIN = pin;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] bits_b2, bits_5a;
    int         frames;
    bits_b2 = 8'hB2;
    bits_5a = 8'h5A;
    frames  = 0;

    step(0, 0, 3'd0, 0, 0, '0);
    step(0, 1, 3'd1, 1, 1, 8'hFF);
    check("rst_pout", POUT, 0);

    // reset with a partial frame and a captured word
    for (int i = 7; i >= 0; i--) step(1, 1, 3'd1, bits_5a[i], 0, '0);
    check("pre_word", WORD_OUT, 8'h5A);
    step(1, 1, 3'd5, 0, 0, 8'hA5);
    for (int i = 0; i < 3; i++) step(1, 1, 3'd1, 0, 0, '0);
    check("pre_cnt", BITCNT, 3);
    step(0, 1, 3'd1, 1, 0, '0);
    check("rst_pout2", POUT, 0);
    check("rst_cnt", BITCNT, 0);
    check("rst_word", WORD_OUT, 0);
    check("rst_vld", WORD_VLD, 0);

    // frame capture
    for (int i = 7; i >= 0; i--) begin
      step(1, 1, 3'd1, bits_b2[i], 0, '0);
      check("cap_vld_during", WORD_VLD, (i == 0));
    end
    check("cap_pout", POUT, 8'hB2);
    check("cap_word", WORD_OUT, 8'hB2);
    check("cap_cnt", BITCNT, 0);
    step(1, 1, 3'd0, 0, 0, '0);
    check("cap_vld_drop", WORD_VLD, 0);

    // rotate / shift
    step(1, 1, 3'd5, 0, 0, 8'h81);
    step(1, 1, 3'd3, 0, 0, '0);
    check("rol", POUT, 8'h03);
    step(1, 1, 3'd5, 0, 0, 8'h81);
    step(1, 1, 3'd4, 0, 0, '0);
    check("ror", POUT, 8'hC0);
    check("ror_cnt", BITCNT, 0);
    step(1, 1, 3'd5, 0, 0, 8'h81);
    check("sout_r_pre", SOUT_R, 1);
    step(1, 1, 3'd2, 0, 0, '0);
    check("shr", POUT, 8'h40);

    // enable gating
    step(1, 1, 3'd6, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 1, 3'd1, 1, 0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 3'd1, 0, 0, '0);
    check("gate_pout", POUT, 8'h07);
    check("gate_cnt", BITCNT, 3);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 3'd1, 0, 0, '0);
      check("gate_vld", WORD_VLD, (i == 4));
    end

    // abort by load / clear
    for (int i = 0; i < 5; i++) step(1, 1, 3'd2, 1, 1, '0);
    check("abort_pre", BITCNT, 5);
    step(1, 1, 3'd5, 0, 0, 8'h3C);
    check("abort_pout", POUT, 8'h3C);
    check("abort_cnt", BITCNT, 0);
    check("abort_vld", WORD_VLD, 0);
    step(1, 1, 3'd6, 0, 0, '0);
    check("clear", POUT, 0);

    // MODE 111
    step(1, 1, 3'd5, 0, 0, 8'h80);
    step(1, 1, 3'd7, 0, 0, '0);
`ifdef SHIFT_REG_ARITH_SHIFT_EN
    check("mode7", POUT, 8'hC0);
`else
    check("mode7", POUT, 8'h80);
`endif
    check("mode7_cnt", BITCNT, 0);

    // randomized traffic, biased toward counting shifts
    for (int i = 0; i < 600; i++) begin
      logic       r, e;
      logic [2:0] m;
      r = ($urandom_range(0, 79) != 0);
      e = ($urandom_range(0, 7) != 0);
      m = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 2)) : 3'($urandom_range(0, 7));
      step(r, e, m, 1'($urandom), 1'($urandom), 8'($urandom));
      if (m_vld != 0) frames++;
    end
    if (frames == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rand_frames: got=0 expected>0");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
